stream_demux_1x4: RTL and testbench
===================================

STREAM_DEMUX_1X4 -- requirements
Module: stream_demux_1x4

Interface
REQ-001 Parameter DATA_W, default 8, sets the width of each data beat.
REQ-002 Parameter FIFO_DEPTH, default 2, sets the number of entries in each per-channel output FIFO; it SHALL be fixed at 2 in this revision.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  the upstream beat is valid.
REQ-006 in_ready  output  1  the block accepts the beat this cycle.
REQ-007 in_data  input  DATA_W  beat payload.
REQ-008 in_sel  input  2  destination channel, where {a,b} = 00/01/10/11 maps to channels 0/1/2/3.
REQ-009 in_last  input  1  the beat is the final beat of a packet.
REQ-010 out_valid  output  4  per-channel valid; bit k belongs to channel k.
REQ-011 out_ready  input  4  per-channel ready from the downstream consumer.
REQ-012 out_data  output  4*DATA_W  flattened per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 out_last  output  4  per-channel last flag.
REQ-014 busy  output  1  high while a packet is in progress.
REQ-015 cur_sel  output  2  the channel latched for the current packet.

Function
REQ-016 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-017 The FSM SHALL have exactly two states, IDLE and BUSY:
- IDLE -> BUSY when a beat is accepted with in_last=0.
- BUSY -> IDLE when a beat is accepted with in_last=1.
- A single-beat packet (in_last=1) accepted in IDLE SHALL leave the FSM in IDLE.
REQ-018 Channel routing SHALL depend on the state:
- In IDLE, the target channel is in_sel, and cur_sel SHALL load in_sel on every accepted beat.
- In BUSY, in_sel SHALL be ignored and the target channel is cur_sel.
REQ-019 in_ready SHALL equal "the target channel's FIFO is not full".
- in_ready SHALL NOT depend combinationally on out_ready.
- A full FIFO that is popped this cycle SHALL still deassert in_ready this cycle.
REQ-020 An accepted beat SHALL be pushed, as the pair {in_data, in_last}, only into the target channel's FIFO; the other FIFOs SHALL NOT change.
REQ-021 Each channel FIFO SHALL be first-in first-out:
- out_valid[k] SHALL be high when FIFO k is not empty.
- out_data and out_last for channel k SHALL present the FIFO head.
- The head SHALL be popped when out_valid[k] and out_ready[k] are both high.
REQ-022 Latency SHALL be exactly 1 cycle: a beat accepted at edge N SHALL appear on out_valid/out_data at edge N (visible in cycle N+1) if FIFO k was empty.
REQ-023 A simultaneous push and pop on the same FIFO SHALL leave the occupancy unchanged and preserve order.
REQ-024 Channels SHALL drain independently: a stalled out_ready[j] SHALL NOT block a packet routed to channel k != j.
REQ-025 busy SHALL equal (state == BUSY).
REQ-026 When in_valid=0, no state SHALL change except FIFO pops.

Reset
REQ-027 On rst_n=0, independent of clk, the block SHALL reset as follows:
- FSM to IDLE, with cur_sel=0 and busy=0.
- All FIFOs emptied, so out_valid=0.
- out_data=0 and out_last=0.
- in_ready=1.
REQ-028 A reset asserted mid-packet SHALL discard the partial packet; after release, the next accepted beat SHALL be treated as the start of a new packet.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-030 A shared package demux_pkg SHALL hold:
- the constant NUM_CH=4;
- the constant SEL_W=2;
- the state enum {IDLE, BUSY}.
REQ-031 The per-channel FIFO SHALL be a sub-module stream_fifo2 (DATA_W+1 bits wide, 2 entries, with push/pop/full/empty), instantiated 4 times.
REQ-032 Routing and FSM logic SHALL reside in stream_demux_1x4; there SHALL be no other sub-modules.

Verification
REQ-033 Reset followed by one beat: in_sel=10, data=0x5A, last=1 -> cycle+1 shows out_valid=0100, channel-2 data=0x5A, out_last[2]=1, busy=0.
REQ-034 Three-beat packet with sel=01 and data 0x11, 0x22, 0x33 (last on 0x33), with in_sel toggled to 11 after the first beat -> all three beats arrive only on channel 1, in order; busy is high from the 1st to the 3rd acceptance.
REQ-035 out_ready[3]=0 and four beats sent to channel 3 -> in_ready falls after 2 accepted beats; raising out_ready[3] drains 0xA0 then 0xA1, after which the remaining beats are accepted.
REQ-036 Channel 0 stalled and full, then a packet to channel 2 -> channel 2 receives its beats with 1-cycle latency, unaffected by channel 0.
REQ-037 rst_n pulsed low after the 2nd beat of a 4-beat packet to channel 1 -> out_valid=0000 and busy=0 immediately (asynchronous reset); the next beat with sel=00 lands on channel 0.
REQ-038 Channel 1 FIFO full with out_ready[1]=1 and in_valid=1 -> one pop and no push in that cycle; a push follows in the next cycle; the beat order is intact.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-in first-out buffer with a registered head; used once per output channel.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);
    assign dout    = head;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head always holds the oldest entry; tail is only meaningful when count is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // A push needs a free slot, so only count==1 reaches here.
                    head <= din;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux_1x4.sv
// Routes packets from one input stream to one of four buffered output channels,
// holding the channel chosen by the first beat for the remainder of the packet.
module stream_demux_1x4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic                     busy,
    output logic [SEL_W-1:0]         cur_sel
);

    state_t            state;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  target;
    logic              accept;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [DATA_W:0]   head [NUM_CH];

    assign target    = (state == IDLE) ? in_sel : sel_q;
    // Only the target FIFO's fullness gates acceptance; out_ready never reaches in_ready.
    assign in_ready  = ~full[target];
    assign accept    = in_valid & in_ready;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign busy      = (state == BUSY);
    assign cur_sel   = sel_q;

    always_comb begin
        push = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            push[i] = accept && (target == SEL_W'(i));
        end
    end

    always_comb begin
        out_data = '0;
        out_last = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            out_data[i*DATA_W +: DATA_W] = head[i][DATA_W-1:0];
            out_last[i]                  = head[i][DATA_W];
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        stream_fifo2 #(
            .WIDTH (DATA_W + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   ({in_last, in_data}),
            .full  (full[k]),
            .empty (empty[k]),
            .dout  (head[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
        end else if (accept) begin
            if (state == IDLE) sel_q <= in_sel;
            state <= in_last ? IDLE : BUSY;
        end
    end

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Randomised and directed checks of stream_demux_1x4 against a queue-based packet model.
module tb_stream_demux_1x4;

    typedef logic [8:0] beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic        busy;
    logic [1:0]  cur_sel;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model: one queue per channel, plus packet-in-progress flag and held channel.
    beat_t       mq [4][$];
    logic        m_busy;
    logic [1:0]  m_sel;

    stream_demux_1x4 #(
        .DATA_W     (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .cur_sel   (cur_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_busy = 1'b0;
        m_sel  = 2'd0;
    endtask

    // Asserts reset between edges and checks the asynchronous reset values before any clock.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cur_sel", cur_sel, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", out_last, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, compare every output against the model, advance model at the edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                        input logic l, input logic [3:0] rdy, output logic ir);
        logic [1:0] tgt;
        logic       exp_ir;
        beat_t      b;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        in_last   = l;
        out_ready = rdy;
        #1;
        tgt    = m_busy ? m_sel : sel;
        exp_ir = (mq[tgt].size() < 2);
        ir     = in_ready;
        chk("in_ready", in_ready, exp_ir);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), out_valid[k], mq[k].size() != 0);
            if (mq[k].size() != 0) begin
                b = mq[k][0];
                chk($sformatf("out_data[%0d]", k), out_data[k*8 +: 8], b[7:0]);
                chk($sformatf("out_last[%0d]", k), out_last[k], b[8]);
            end
        end
        chk("busy", busy, m_busy);
        chk("cur_sel", cur_sel, m_sel);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
        end
        if (v && exp_ir) begin
            mq[tgt].push_back({l, d});
            if (!m_busy) m_sel = sel;
            m_busy = !l;
        end
        #1;
    endtask

    task automatic drain();
        logic ir;
        repeat (3) step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, ir);
    endtask

    initial begin
        logic ir;
        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 4'h0;
        model_clear();
        apply_reset();

        // Single-beat packet to channel 2.
        step(1'b1, 2'b10, 8'h5A, 1'b1, 4'h0, ir);
        chk("r33_valid", out_valid, 4'b0100);
        chk("r33_data", out_data[23:16], 8'h5A);
        chk("r33_last", out_last[2], 1'b1);
        chk("r33_busy", busy, 1'b0);
        drain();

        // Three-beat packet to channel 1, in_sel changed mid-packet.
        step(1'b1, 2'b01, 8'h11, 1'b0, 4'b0010, ir);
        chk("r34_b1_valid", out_valid, 4'b0010);
        chk("r34_b1_data", out_data[15:8], 8'h11);
        chk("r34_b1_busy", busy, 1'b1);
        step(1'b1, 2'b11, 8'h22, 1'b0, 4'b0010, ir);
        chk("r34_b2_valid", out_valid, 4'b0010);
        chk("r34_b2_data", out_data[15:8], 8'h22);
        chk("r34_b2_busy", busy, 1'b1);
        step(1'b1, 2'b11, 8'h33, 1'b1, 4'b0010, ir);
        chk("r34_b3_valid", out_valid, 4'b0010);
        chk("r34_b3_data", out_data[15:8], 8'h33);
        chk("r34_b3_last", out_last[1], 1'b1);
        chk("r34_b3_busy", busy, 1'b0);
        drain();

        // Backpressure on channel 3.
        step(1'b1, 2'd3, 8'hA0, 1'b0, 4'h0, ir);
        chk("r35_acc0", ir, 1'b1);
        step(1'b1, 2'd3, 8'hA1, 1'b0, 4'h0, ir);
        chk("r35_acc1", ir, 1'b1);
        step(1'b1, 2'd3, 8'hA2, 1'b0, 4'h0, ir);
        chk("r35_stall", ir, 1'b0);
        chk("r35_head0", out_data[31:24], 8'hA0);
        step(1'b1, 2'd3, 8'hA2, 1'b0, 4'b1000, ir);
        chk("r35_stall_on_pop", ir, 1'b0);
        chk("r35_head1", out_data[31:24], 8'hA1);
        step(1'b1, 2'd3, 8'hA2, 1'b0, 4'b1000, ir);
        chk("r35_acc2", ir, 1'b1);
        step(1'b1, 2'd3, 8'hA3, 1'b1, 4'b1000, ir);
        chk("r35_acc3", ir, 1'b1);
        drain();

        // Channel 0 stalled full; channel 2 must still flow.
        step(1'b1, 2'd0, 8'hC0, 1'b1, 4'h0, ir);
        step(1'b1, 2'd0, 8'hC1, 1'b1, 4'h0, ir);
        step(1'b1, 2'd0, 8'hC2, 1'b1, 4'h0, ir);
        chk("r36_ch0_full", ir, 1'b0);
        step(1'b1, 2'd2, 8'hD0, 1'b0, 4'b0100, ir);
        chk("r36_d0_valid", out_valid, 4'b0101);
        chk("r36_d0_data", out_data[23:16], 8'hD0);
        step(1'b1, 2'd2, 8'hD1, 1'b1, 4'b0100, ir);
        chk("r36_d1_valid", out_valid, 4'b0101);
        chk("r36_d1_data", out_data[23:16], 8'hD1);
        drain();

        // Reset mid-packet; the next beat starts a fresh packet.
        step(1'b1, 2'd1, 8'h41, 1'b0, 4'h0, ir);
        step(1'b1, 2'd1, 8'h42, 1'b0, 4'h0, ir);
        apply_reset();
        step(1'b1, 2'd0, 8'h55, 1'b1, 4'h0, ir);
        chk("r37_valid", out_valid, 4'b0001);
        chk("r37_data", out_data[7:0], 8'h55);
        drain();

        // Full channel 1 popped and pushed on consecutive cycles.
        step(1'b1, 2'd1, 8'h61, 1'b0, 4'h0, ir);
        step(1'b1, 2'd1, 8'h62, 1'b0, 4'h0, ir);
        step(1'b1, 2'd1, 8'h63, 1'b1, 4'b0010, ir);
        chk("r38_no_push", ir, 1'b0);
        chk("r38_head62", out_data[15:8], 8'h62);
        step(1'b1, 2'd1, 8'h63, 1'b1, 4'b0010, ir);
        chk("r38_push", ir, 1'b1);
        chk("r38_head63", out_data[15:8], 8'h63);
        chk("r38_last", out_last[1], 1'b1);
        drain();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 699) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     8'($urandom), $urandom_range(0, 3) == 0,
                     4'($urandom), ir);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
